// File: rtl/async_fifo_pkg.sv
// rtl/async_fifo_pkg.sv - Pointer-code helpers and output-stage state type for the async FIFO read side
package async_fifo_pkg;

  localparam int PTR_MAX_W = 32;

  typedef logic [PTR_MAX_W-1:0] ptr_word_t;

  typedef enum logic [1:0] {
    STG_EMPTY = 2'd0,
    STG_ONE   = 2'd1,
    STG_TWO   = 2'd2
  } stg_state_t;

  // Both helpers take zero-extended pointers; leading zeros are neutral in either code.
  function automatic ptr_word_t bin2gray(input ptr_word_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic ptr_word_t gray2bin(input ptr_word_t g);
    ptr_word_t b;
    b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/async_fifo_rd_ctrl_if.sv
// rtl/async_fifo_rd_ctrl_if.sv - Consumer-side valid/ready read stream of the async FIFO
interface async_fifo_rd_ctrl_if #(
  parameter int DSIZE = 8
);

  logic             rd_valid;
  logic             rd_ready;
  logic [DSIZE-1:0] rd_data;

  modport master (
    output rd_valid,
    output rd_data,
    input  rd_ready
  );

  modport slave (
    input  rd_valid,
    input  rd_data,
    output rd_ready
  );

endinterface

// File: rtl/fifo_fwft_stage.sv
// rtl/fifo_fwft_stage.sv - Two-entry (main + skid) output stage, built only when RD_FWFT_EN is defined
`ifdef RD_FWFT_EN
module fifo_fwft_stage
  import async_fifo_pkg::*;
#(
  parameter int DSIZE = 8
) (
  input  logic             dest_clk,
  input  logic             dest_rst_n,
  input  logic             i_valid,
  input  logic [DSIZE-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [DSIZE-1:0] o_data,
  output logic [1:0]       o_count
);

  stg_state_t       r_state;
  stg_state_t       w_state_next;
  logic [DSIZE-1:0] r_main;
  logic [DSIZE-1:0] r_skid;
  logic             w_push;
  logic             w_pop;

  assign w_push = i_valid;
  assign w_pop  = o_valid & i_ready;

  always_ff @(posedge dest_clk or negedge dest_rst_n) begin
    if (!dest_rst_n) begin
      r_state <= STG_EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      STG_EMPTY: if (w_push) w_state_next = STG_ONE;
      STG_ONE: begin
        if (w_push && !w_pop)      w_state_next = STG_TWO;
        else if (!w_push && w_pop) w_state_next = STG_EMPTY;
      end
      STG_TWO:   if (w_pop && !w_push) w_state_next = STG_ONE;
      default:   w_state_next = STG_EMPTY;
    endcase
  end

  always_comb begin
    o_valid = (r_state != STG_EMPTY);
    o_data  = r_main;
    case (r_state)
      STG_ONE: o_count = 2'd1;
      STG_TWO: o_count = 2'd2;
      default: o_count = 2'd0;
    endcase
  end

  // The head word always lives in r_main so rd_data never moves under backpressure.
  always_ff @(posedge dest_clk or negedge dest_rst_n) begin
    if (!dest_rst_n) begin
      r_main <= '0;
      r_skid <= '0;
    end else begin
      case (r_state)
        STG_EMPTY: if (w_push) r_main <= i_data;
        STG_ONE: begin
          if (w_push && w_pop) r_main <= i_data;
          else if (w_push)     r_skid <= i_data;
        end
        STG_TWO: begin
          if (w_pop) begin
            r_main <= r_skid;
            if (w_push) r_skid <= i_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`endif

// File: rtl/async_fifo_rd_ctrl.sv
// rtl/async_fifo_rd_ctrl.sv - Read-domain controller of the dual-clock FIFO; RD_FWFT_EN selects first-word-fall-through output
module async_fifo_rd_ctrl
  import async_fifo_pkg::*;
#(
  parameter int          ASIZE      = 4,
  parameter int          DSIZE      = 8,
  parameter int unsigned AEMPTY_THR = 2
) (
  input  logic               dest_clk,
  input  logic               dest_rst_n,
  input  logic [ASIZE:0]     rq2_wptr,
  output logic [ASIZE:0]     rptr,
  output logic [ASIZE-1:0]   raddr,
  output logic               ren,
  input  logic [DSIZE-1:0]   rdata_ram,
  async_fifo_rd_ctrl_if.master rd_if,
  output logic               rempty,
  output logic               raempty,
  output logic [ASIZE:0]     rlevel
);

  localparam int PW = ASIZE + 1;

  logic [ASIZE:0] r_rbin;
  logic [ASIZE:0] r_rptr;
  logic [ASIZE:0] r_rlevel;
  logic           r_rempty;
  logic           r_raempty;

  logic           w_req;
  logic           w_pop;
  logic [ASIZE:0] w_rbin_next;
  logic [ASIZE:0] w_rgray_next;
  logic [ASIZE:0] w_wbin;
  logic [ASIZE:0] w_diff;

  // Gating on the registered empty keeps a same-cycle write-pointer change from being popped early.
  assign w_pop        = w_req & ~r_rempty;
  assign w_rbin_next  = r_rbin + {{ASIZE{1'b0}}, w_pop};
  assign w_rgray_next = PW'(bin2gray(PTR_MAX_W'(w_rbin_next)));
  assign w_wbin       = PW'(gray2bin(PTR_MAX_W'(rq2_wptr)));
  assign w_diff       = w_wbin - w_rbin_next;

  always_ff @(posedge dest_clk or negedge dest_rst_n) begin
    if (!dest_rst_n) begin
      r_rbin    <= '0;
      r_rptr    <= '0;
      r_rempty  <= 1'b1;
      r_raempty <= 1'b1;
      r_rlevel  <= '0;
    end else begin
      r_rbin    <= w_rbin_next;
      r_rptr    <= w_rgray_next;
      r_rempty  <= (w_rgray_next == rq2_wptr);
      r_rlevel  <= w_diff;
      r_raempty <= (PTR_MAX_W'(w_diff) <= AEMPTY_THR);
    end
  end

  assign rptr    = r_rptr;
  assign raddr   = r_rbin[ASIZE-1:0];
  assign ren     = w_pop;
  assign rempty  = r_rempty;
  assign raempty = r_raempty;
  assign rlevel  = r_rlevel;

`ifdef RD_FWFT_EN
  logic       r_inflight;
  logic [1:0] w_count;
  logic       w_xfer;
  logic [2:0] w_pending;

  always_ff @(posedge dest_clk or negedge dest_rst_n) begin
    if (!dest_rst_n) begin
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_pop;
    end
  end

  // Request only when the word it fetches is sure of a slot next cycle, counting the one still in the RAM.
  assign w_xfer    = rd_if.rd_valid & rd_if.rd_ready;
  assign w_pending = {1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_xfer};
  assign w_req     = (w_pending < 3'd2);

  fifo_fwft_stage #(
    .DSIZE (DSIZE)
  ) u_stage (
    .dest_clk   (dest_clk),
    .dest_rst_n (dest_rst_n),
    .i_valid    (r_inflight),
    .i_data     (rdata_ram),
    .o_valid    (rd_if.rd_valid),
    .i_ready    (rd_if.rd_ready),
    .o_data     (rd_if.rd_data),
    .o_count    (w_count)
  );
`else
  logic             r_rd_valid;
  logic [DSIZE-1:0] r_hold;

  assign w_req = rd_if.rd_ready;

  always_ff @(posedge dest_clk or negedge dest_rst_n) begin
    if (!dest_rst_n) begin
      r_rd_valid <= 1'b0;
      r_hold     <= '0;
    end else begin
      r_rd_valid <= w_pop;
      if (r_rd_valid) r_hold <= rdata_ram;
    end
  end

  assign rd_if.rd_valid = r_rd_valid;
  assign rd_if.rd_data  = r_rd_valid ? rdata_ram : r_hold;
`endif

endmodule

// File: tb/tb_async_fifo_rd_ctrl.sv
// tb/tb_async_fifo_rd_ctrl.sv - Self-checking bench for async_fifo_rd_ctrl (default and RD_FWFT_EN builds)
module tb_async_fifo_rd_ctrl;

  localparam int ASIZE = 4;
  localparam int DSIZE = 8;

  typedef struct {
    logic       rdy;
    logic [4:0] wptr;
    logic       e_ren;
    logic [3:0] e_raddr;
    logic       e_rempty;
    logic       e_raempty;
    logic [4:0] e_rlevel;
    logic [4:0] e_rptr;
  } vec_t;

  logic             dest_clk;
  logic             dest_rst_n;
  logic [ASIZE:0]   rq2_wptr;
  logic [ASIZE:0]   rptr;
  logic [ASIZE-1:0] raddr;
  logic             ren;
  logic [DSIZE-1:0] rdata_ram;
  logic             rempty;
  logic             raempty;
  logic [ASIZE:0]   rlevel;

  async_fifo_rd_ctrl_if #(.DSIZE(DSIZE)) rd_if ();

  async_fifo_rd_ctrl #(
    .ASIZE      (ASIZE),
    .DSIZE      (DSIZE),
    .AEMPTY_THR (2)
  ) dut (
    .dest_clk   (dest_clk),
    .dest_rst_n (dest_rst_n),
    .rq2_wptr   (rq2_wptr),
    .rptr       (rptr),
    .raddr      (raddr),
    .ren        (ren),
    .rdata_ram  (rdata_ram),
    .rd_if      (rd_if),
    .rempty     (rempty),
    .raempty    (raempty),
    .rlevel     (rlevel)
  );

  vec_t       vecs[$];
  logic [7:0] mem[16];
  logic [7:0] exp_q[$];
  logic [4:0] wbin;
  int         n_checks;
  int         n_errors;

  initial dest_clk = 1'b0;
  always #5 dest_clk = ~dest_clk;

  always @(posedge dest_clk) begin
    if (ren) rdata_ram <= mem[raddr];
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [4:0] gray(input int b);
    logic [4:0] v;
    v = 5'(b);
    return v ^ (v >> 1);
  endfunction

  function automatic vec_t mk(input logic rdy, input logic [4:0] wp, input logic e_ren,
                              input logic [3:0] e_addr, input logic e_emp, input logic e_ae,
                              input logic [4:0] e_lvl, input logic [4:0] e_rp);
    vec_t v;
    v.rdy = rdy; v.wptr = wp; v.e_ren = e_ren; v.e_raddr = e_addr;
    v.e_rempty = e_emp; v.e_raempty = e_ae; v.e_rlevel = e_lvl; v.e_rptr = e_rp;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic write_word(input logic [7:0] d);
    mem[wbin[3:0]] = d;
    exp_q.push_back(d);
    wbin = wbin + 5'd1;
  endtask

  task automatic do_reset();
    dest_rst_n = 1'b0;
    rq2_wptr = '0;
    rd_if.rd_ready = 1'b0;
    wbin = '0;
    exp_q.delete();
    repeat (2) @(posedge dest_clk);
    #1 dest_rst_n = 1'b1;
  endtask

  task automatic run_vecs(input string tag);
    foreach (vecs[i]) begin
      @(posedge dest_clk); #1;
      rd_if.rd_ready = vecs[i].rdy;
      rq2_wptr = vecs[i].wptr;
      @(negedge dest_clk);
      chk($sformatf("%s[%0d].ren", tag, i), int'(ren), int'(vecs[i].e_ren));
      chk($sformatf("%s[%0d].raddr", tag, i), int'(raddr), int'(vecs[i].e_raddr));
      chk($sformatf("%s[%0d].rempty", tag, i), int'(rempty), int'(vecs[i].e_rempty));
      chk($sformatf("%s[%0d].raempty", tag, i), int'(raempty), int'(vecs[i].e_raempty));
      chk($sformatf("%s[%0d].rlevel", tag, i), int'(rlevel), int'(vecs[i].e_rlevel));
      chk($sformatf("%s[%0d].rptr", tag, i), int'(rptr), int'(vecs[i].e_rptr));
    end
    vecs.delete();
  endtask

  // Scoreboard: every word the consumer takes must be the oldest word written.
  always @(negedge dest_clk) begin
    if (dest_rst_n && rd_if.rd_valid
`ifdef RD_FWFT_EN
        && rd_if.rd_ready
`endif
       ) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL sb_underflow: got word %0h with none expected", rd_if.rd_data);
      end else begin
        chk("sb_data", int'(rd_if.rd_data), int'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    bit hit;
    int pops;
    n_checks = 0; n_errors = 0;
    wbin = '0; rq2_wptr = '0; rd_if.rd_ready = 1'b0; dest_rst_n = 1'b0;
    repeat (3) @(posedge dest_clk);
    #1 dest_rst_n = 1'b1;
    rd_if.rd_ready = 1'b1;
    @(negedge dest_clk);
    chk("rst.rempty", int'(rempty), 1);
    chk("rst.raempty", int'(raempty), 1);
    chk("rst.rlevel", int'(rlevel), 0);
    chk("rst.rptr", int'(rptr), 0);
    chk("rst.rd_valid", int'(rd_if.rd_valid), 0);
    chk("rst.rd_data", int'(rd_if.rd_data), 0);
    chk("rst.ren", int'(ren), 0);

    // Single word: pointer 0->1, pop, empty again
    write_word(8'h5a);
    vecs.push_back(mk(1'b1, 5'd0, 1'b0, 4'd0, 1'b1, 1'b1, 5'd0, 5'd0));
    vecs.push_back(mk(1'b0, 5'd1, 1'b0, 4'd0, 1'b1, 1'b1, 5'd0, 5'd0));
    vecs.push_back(mk(1'b1, 5'd1, 1'b1, 4'd0, 1'b0, 1'b1, 5'd1, 5'd0));
    vecs.push_back(mk(1'b1, 5'd1, 1'b0, 4'd1, 1'b1, 1'b1, 5'd0, 5'd1));
    vecs.push_back(mk(1'b1, 5'd1, 1'b0, 4'd1, 1'b1, 1'b1, 5'd0, 5'd1));
    run_vecs("step");

    // Full 16-word burst under continuous ready
    do_reset();
    for (int k = 0; k < 16; k++) write_word(8'($urandom_range(0, 255)));
    vecs.push_back(mk(1'b1, 5'd24, 1'b0, 4'd0, 1'b1, 1'b1, 5'd0, 5'd0));
    for (int k = 0; k < 16; k++) begin
      vecs.push_back(mk(1'b1, 5'd24, 1'b1, 4'(k), 1'b0, ((16 - k) <= 2), 5'(16 - k), gray(k)));
    end
    vecs.push_back(mk(1'b1, 5'd24, 1'b0, 4'd0, 1'b1, 1'b1, 5'd0, 5'd24));
    run_vecs("burst");

    // Advance both pointers to 30, one Gray step per cycle
    for (int k = 0; k < 14; k++) write_word(8'($urandom_range(0, 255)));
    for (int j = 17; j <= 30; j++) begin
      @(posedge dest_clk); #1;
      rq2_wptr = gray(j);
    end
    hit = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge dest_clk);
      if (rempty && rptr == gray(30)) begin hit = 1'b1; break; end
    end
    chk("chase.reached_30", int'(hit), 1);

    // Wrap: rbin 30 -> 2, raddr 14,15,0,1
    for (int k = 0; k < 4; k++) write_word(8'($urandom_range(0, 255)));
    vecs.push_back(mk(1'b1, 5'd16, 1'b0, 4'd14, 1'b1, 1'b1, 5'd0, 5'd17));
    vecs.push_back(mk(1'b1, 5'd0,  1'b1, 4'd14, 1'b0, 1'b1, 5'd1, 5'd17));
    vecs.push_back(mk(1'b1, 5'd1,  1'b1, 4'd15, 1'b0, 1'b1, 5'd1, 5'd16));
    vecs.push_back(mk(1'b1, 5'd3,  1'b1, 4'd0,  1'b0, 1'b1, 5'd1, 5'd0));
    vecs.push_back(mk(1'b1, 5'd3,  1'b1, 4'd1,  1'b0, 1'b1, 5'd1, 5'd1));
    vecs.push_back(mk(1'b1, 5'd3,  1'b0, 4'd2,  1'b1, 1'b1, 5'd0, 5'd3));
    run_vecs("wrap");

    // Reset in the middle of a burst at rlevel=5
    do_reset();
    for (int k = 0; k < 16; k++) write_word(8'($urandom_range(0, 255)));
    @(posedge dest_clk); #1;
    rq2_wptr = 5'd24;
    rd_if.rd_ready = 1'b1;
    hit = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge dest_clk);
      if (rlevel == 5'd5) begin hit = 1'b1; break; end
    end
    chk("midrst.reached_lvl5", int'(hit), 1);
    #1;
    dest_rst_n = 1'b0;
    exp_q.delete();
    rq2_wptr = '0;
    wbin = '0;
    #1;
    chk("midrst.rempty", int'(rempty), 1);
    chk("midrst.raempty", int'(raempty), 1);
    chk("midrst.rlevel", int'(rlevel), 0);
    chk("midrst.rptr", int'(rptr), 0);
    chk("midrst.raddr", int'(raddr), 0);
    chk("midrst.ren", int'(ren), 0);
    chk("midrst.rd_valid", int'(rd_if.rd_valid), 0);
    chk("midrst.rd_data", int'(rd_if.rd_data), 0);
    @(posedge dest_clk);
    @(posedge dest_clk); #1;
    dest_rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge dest_clk);
      chk($sformatf("postrst[%0d].rempty", c), int'(rempty), 1);
      chk($sformatf("postrst[%0d].ren", c), int'(ren), 0);
      chk($sformatf("postrst[%0d].rd_valid", c), int'(rd_if.rd_valid), 0);
    end
    @(posedge dest_clk); #1;
    write_word(8'h3c);
    rq2_wptr = gray(1);
    @(negedge dest_clk);
    chk("reseen.rempty_old", int'(rempty), 1);
    @(negedge dest_clk);
    chk("reseen.rempty", int'(rempty), 0);
    chk("reseen.ren", int'(ren), 1);
    chk("reseen.rlevel", int'(rlevel), 1);
    repeat (4) @(posedge dest_clk);

`ifdef RD_FWFT_EN
    // Backpressure: three words, ready low, only two fetched
    #1 rd_if.rd_ready = 1'b0;
    write_word(8'ha0);
    write_word(8'ha1);
    write_word(8'ha2);
    pops = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge dest_clk); #1;
      if (c < 3) rq2_wptr = gray(c + 2);
      @(negedge dest_clk);
      if (ren) pops++;
    end
    chk("fwft.pops_held", pops, 2);
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("fwft.hold[%0d].valid", c), int'(rd_if.rd_valid), 1);
      chk($sformatf("fwft.hold[%0d].data", c), int'(rd_if.rd_data), 'ha0);
      @(negedge dest_clk);
    end
    @(posedge dest_clk); #1;
    rd_if.rd_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge dest_clk);
      chk($sformatf("fwft.drain[%0d].valid", k), int'(rd_if.rd_valid), 1);
      chk($sformatf("fwft.drain[%0d].data", k), int'(rd_if.rd_data), 'ha0 + k);
    end
    @(negedge dest_clk);
    chk("fwft.drain_end.valid", int'(rd_if.rd_valid), 0);
`endif

    repeat (4) @(posedge dest_clk);
    @(negedge dest_clk);
    chk("sb.drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
